// File: rtl/ir_command_scheduler.sv
// ir_command_scheduler: holds the bus-written command and repeat mode and
// arbitrates between the bus and local requesters. On every period tick with a
// request pending, it issues one packet to the slow IR transmitter using a
// level send/busy handshake. Both waits in the handshake are bounded by a
// timeout that raises a sticky ERROR flag.
module ir_command_scheduler #(
   parameter logic [7:0] IO_ADDRESS     = 8'h90,
   parameter int         PERIOD_CYCLES  = 10_000_000,
   parameter int         TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       BUS_WE,
   input  logic [7:0] BUS_ADDR,
   input  logic [7:0] BUS_DATA,
   input  logic       LOCAL_REQ,
   input  logic [3:0] LOCAL_CMD,
   input  logic       TX_BUSY,
   output logic       SEND_PACKET,
   output logic [3:0] COMMAND,
   output logic       GRANT_LOCAL,
   output logic       ERROR
);

   localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, ARB, REQ, DONE} state_t;

   state_t          state, state_next;
   logic [3:0]      bus_cmd;
   logic            repeat_en;
   logic [PW-1:0]   pcnt;
   logic [TW-1:0]   tcnt;
   logic            tick;
   logic            busy_meta, busy_s;
   logic [3:0]      cmd_r;
   logic            grant_local;
   logic            error_r;
   logic            err_set;
   logic            win_local;
   logic            timeout;
   logic            wr_cmd, wr_ctl;
   logic            bus_req, local_req;

   // Request snapshot taken at the tick, so ARB sees the pre-write values
   logic            snap_bus_req, snap_local_req;
   logic [3:0]      snap_bus_cmd, snap_local_cmd;

   assign wr_cmd    = BUS_WE && (BUS_ADDR == IO_ADDRESS);
   assign wr_ctl    = BUS_WE && (BUS_ADDR == IO_ADDRESS + 8'd1);
   assign bus_req   = repeat_en && (bus_cmd != 4'd0);
   assign local_req = LOCAL_REQ && (LOCAL_CMD != 4'd0);
   assign tick      = (pcnt == PW'(PERIOD_CYCLES - 1));
   assign timeout   = (tcnt == TW'(TIMEOUT_CYCLES - 1));

   // Registers, period/timeout counters, busy synchronizer and FSM state
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         bus_cmd     <= 4'd0;
         repeat_en   <= 1'b0;
         pcnt        <= '0;
         tcnt        <= '0;
         busy_meta   <= 1'b0;
         busy_s      <= 1'b0;
         cmd_r       <= 4'd0;
         grant_local <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         state     <= state_next;
         busy_meta <= TX_BUSY;
         busy_s    <= busy_meta;
         pcnt      <= tick ? '0 : pcnt + PW'(1);
         if (wr_cmd)
            bus_cmd <= BUS_DATA[3:0];
         if (wr_ctl)
            repeat_en <= BUS_DATA[0];
         if (state_next != state)
            tcnt <= '0;
         else if ((state == REQ) || (state == DONE))
            tcnt <= tcnt + TW'(1);
         else
            tcnt <= '0;
         if (state == ARB) begin
            cmd_r       <= win_local ? snap_local_cmd : snap_bus_cmd;
            grant_local <= win_local;
         end
         if (err_set)
            error_r <= 1'b1;
         else if (wr_ctl && BUS_DATA[1])
            error_r <= 1'b0;
      end
   end

   // Capture request state and commands on the tick that starts arbitration
   always_ff @(posedge CLK) begin
      if ((state == IDLE) && tick) begin
         snap_bus_req   <= bus_req;
         snap_local_req <= local_req;
         snap_bus_cmd   <= bus_cmd;
         snap_local_cmd <= LOCAL_CMD;
      end
   end

   // Next-state logic, round-robin grant and timeout detection
   always_comb begin
      state_next = state;
      err_set    = 1'b0;
      win_local  = 1'b0;
      case (state)
         IDLE: begin
            if (tick && (bus_req || local_req))
               state_next = ARB;
         end
         ARB: begin
            // With both requesting, the source opposite the last grant wins
            win_local  = snap_local_req && (!snap_bus_req || !grant_local);
            state_next = REQ;
         end
         REQ: begin
            if (busy_s)
               state_next = DONE;
            else if (timeout) begin
               err_set    = 1'b1;
               state_next = IDLE;
            end
         end
         DONE: begin
            if (!busy_s)
               state_next = IDLE;
            else if (timeout) begin
               err_set    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Decoded from state so reset drops the send request immediately
   assign SEND_PACKET = (state == REQ);
   assign COMMAND     = cmd_r;
   assign GRANT_LOCAL = grant_local;
   assign ERROR       = error_r;

endmodule

// File: doc/ir_command_scheduler.md
# ir_command_scheduler

Packet scheduler and source arbiter in front of the IR transmitter state machine. It holds the bus-written command and repeat mode, and arbitrates between the bus requester and a local manual requester. It times packet repetition from the system clock and drives a level send/busy handshake into the slow (40 kHz) transmitter domain. It replaces the free-running 10 Hz edge-triggered send path, so packets are issued only when a requester is active and the transmitter has finished the previous packet.

## Interface
- IO_ADDRESS, 8'h90, bus address of command register; IO_ADDRESS+1 is control register
- PERIOD_CYCLES, 10_000_000, CLK cycles between packet slots (100 ms at 100 MHz)
- TIMEOUT_CYCLES, 1_000_000, max CLK cycles in any handshake wait state
- CLK  in  1  system clock (100 MHz)
- RESET_N  in  1  asynchronous, active-low reset
- BUS_WE  in  1  bus write strobe
- BUS_ADDR  in  8  bus address
- BUS_DATA  in  8  bus write data
- LOCAL_REQ  in  1  manual requester active (level, synchronous to CLK)
- LOCAL_CMD  in  4  manual command
- TX_BUSY  in  1  transmitter busy, from 40 kHz domain (asynchronous)
- SEND_PACKET  out  1  send request level to transmitter
- COMMAND  out  4  command presented to transmitter
- GRANT_LOCAL  out  1  1 = current or last packet owned by local requester
- ERROR  out  1  sticky handshake-timeout flag

## Operation
- Reset values: all outputs 0. Internal registers reset to 0: bus_cmd, repeat_en, period counter, state=IDLE, last_grant=bus.
- Bus write with BUS_WE=1 and BUS_ADDR==IO_ADDRESS: bus_cmd <= BUS_DATA[3:0].
- Bus write with BUS_WE=1 and BUS_ADDR==IO_ADDRESS+1: repeat_en <= BUS_DATA[0]. If BUS_DATA[1]=1, ERROR clears.
- Writes to any other address are ignored.
- Requests: bus_req = repeat_en && bus_cmd!=0; local_req = LOCAL_REQ && LOCAL_CMD!=0.
- Period counter counts 0..PERIOD_CYCLES-1 and wraps, free-running. tick = 1 when the counter equals PERIOD_CYCLES-1.
- TX_BUSY passes a 2-flop synchronizer, giving busy_s.
- FSM states:
  - IDLE: on tick with any request, go to ARB. A tick with no request, or a tick in any other state, is dropped; there is no queueing.
  - ARB (1 cycle): grant. If only one source requests, that source wins. If both request, round-robin: the source opposite last_grant wins.
  - ARB latches COMMAND from the winner's command, updates last_grant and GRANT_LOCAL, and goes to REQ.
  - REQ: SEND_PACKET=1. When busy_s=1, go to DONE. After TIMEOUT_CYCLES without busy_s, set ERROR and go to IDLE.
  - DONE: SEND_PACKET=0. When busy_s=0, go to IDLE. After TIMEOUT_CYCLES, set ERROR and go to IDLE.
- COMMAND stays stable from ARB until the next ARB. Register writes and requester changes mid-packet do not affect the packet in flight.
- Timeout counter clears on every state entry. Its width is clog2(TIMEOUT_CYCLES+1).
- Period counter width is clog2(PERIOD_CYCLES).
- Write and tick in the same cycle: the arbiter sees the pre-write register values.
- ERROR is sticky across packets. Only reset or a control write with bit1 set clears it. ERROR does not block scheduling.
- RESET_N low mid-packet: SEND_PACKET drops immediately (asynchronously) and the FSM returns to IDLE.

## Timing
- Tick at cycle T with a request present: ARB at T+1, SEND_PACKET=1 from T+2.
- TX_BUSY rise to exit from REQ: 2–3 CLK cycles (synchronizer). SEND_PACKET falls on the cycle after busy_s=1 is sampled.
- SEND_PACKET stays high for at least one 40 kHz period, because it is held until busy is seen.
- Slots are strictly periodic. If a packet outlasts PERIOD_CYCLES, the next packet waits for the first tick after returning to IDLE.

## Test plan
Bench parameters: PERIOD_CYCLES=100, TIMEOUT_CYCLES=50, transmitter model asserting TX_BUSY 10 cycles after SEND_PACKET and holding it for 30 cycles.
- Bus only: write 0x05 to 0x90, then 0x01 to 0x91. Required: one packet per 100 cycles, COMMAND=5, GRANT_LOCAL=0, SEND_PACKET falls 2–3 cycles after TX_BUSY rises.
- Both requesting: bus_cmd=5 with repeat on, LOCAL_REQ=1 with LOCAL_CMD=9. Required: COMMAND alternates 9,5,9,5 (first grant local, since last_grant=bus after reset) and GRANT_LOCAL toggles.
- Timeout: TX_BUSY tied 0. Required: SEND_PACKET high 50 cycles, then ERROR=1 and IDLE. Writing 0x03 to 0x91 clears ERROR. Retries continue each tick.
- Mid-packet write: write 0x07 to 0x90 while in DONE. Required: COMMAND stays 5 until the next ARB, then becomes 7.
- Zero/idle: bus_cmd=0 with repeat on and LOCAL_REQ=0. Required: no SEND_PACKET over 500 cycles. A write to 0x92 changes nothing.
- Reset: RESET_N low while SEND_PACKET=1. Required: all outputs 0 immediately; the first packet after release comes only at the first tick with a request.
